// File: rtl/dot_product_stage_2.sv
// Dot-product stage 2: sums three sign-magnitude products through a 2-deep elastic
// pipeline and emits a saturated sign-magnitude result. Optional: DOT_PRODUCT_STAGE2_OVF_FLAG_EN.

module dot_product_stage_2_sm2tc #(
  parameter int WIDTH = 19
) (
  input  logic [WIDTH-1:0] i_sm,
  output logic [WIDTH:0]   o_tc
);
  logic [WIDTH:0] w_mag;

  assign w_mag = {2'b00, i_sm[WIDTH-2:0]};
  // -0 negates to 0, so negative zero vanishes here.
  assign o_tc  = i_sm[WIDTH-1] ? -w_mag : w_mag;
endmodule

module dot_product_stage_2 #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] stage2_in_x,
  input  logic [WIDTH-1:0] stage2_in_y,
  input  logic [WIDTH-1:0] stage2_in_z,
  input  logic             stage2_in_valid,
  output logic             stage2_in_ready,
  output logic [WIDTH-1:0] stage2_out,
  output logic             stage2_out_valid,
  input  logic             stage2_out_ready
`ifdef DOT_PRODUCT_STAGE2_OVF_FLAG_EN
  ,
  output logic             stage2_out_ovf
`endif
);
  localparam int              NUM_LANES = 3;
  localparam int              SW        = WIDTH + 2;
  localparam logic [WIDTH-2:0] MAG_MAX  = '1;

  logic [NUM_LANES-1:0][WIDTH-1:0] w_sm;
  logic [NUM_LANES-1:0][WIDTH:0]   w_tc;
  logic [SW-1:0]                   w_xy;
  logic [SW-1:0]                   w_sum;
  logic [SW-1:0]                   w_abs;
  logic                            w_neg;
  logic                            w_ovf;
  logic [WIDTH-1:0]                w_res;
  logic                            w_en1;
  logic                            w_en2;

  logic [2:1]                      r_vld_pipe;
  logic [SW-1:0]                   r_s_xy;
  logic [WIDTH:0]                  r_s_z;
  logic [WIDTH-1:0]                r_out;
  logic                            r_ovf;

  assign w_sm = {stage2_in_z, stage2_in_y, stage2_in_x};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dot_product_stage_2_sm2tc #(.WIDTH(WIDTH)) u_cvt (
      .i_sm (w_sm[g]),
      .o_tc (w_tc[g])
    );
  end

  // Ready depends only on pipeline occupancy and downstream ready.
  assign w_en2           = !r_vld_pipe[2] || stage2_out_ready;
  assign w_en1           = !r_vld_pipe[1] || w_en2;
  assign stage2_in_ready = w_en1;

  assign w_xy = {w_tc[0][WIDTH], w_tc[0]} + {w_tc[1][WIDTH], w_tc[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_s_xy        <= '0;
      r_s_z         <= '0;
    end else if (w_en1) begin
      r_vld_pipe[1] <= stage2_in_valid;
      if (stage2_in_valid) begin
        r_s_xy <= w_xy;
        r_s_z  <= w_tc[2];
      end
    end
  end

  // Three 18-bit magnitudes fit well inside SW bits, so the sum cannot wrap.
  assign w_sum = r_s_xy + {r_s_z[WIDTH], r_s_z};
  assign w_neg = w_sum[SW-1];
  assign w_abs = w_neg ? -w_sum : w_sum;
  assign w_ovf = w_abs > {3'b000, MAG_MAX};
  assign w_res = {w_neg, w_ovf ? MAG_MAX : w_abs[WIDTH-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[2] <= 1'b0;
      r_out         <= '0;
      r_ovf         <= 1'b0;
    end else if (w_en2) begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) begin
        r_out <= w_res;
        r_ovf <= w_ovf;
      end
    end
  end

  assign stage2_out       = r_out;
  assign stage2_out_valid = r_vld_pipe[2];

`ifdef DOT_PRODUCT_STAGE2_OVF_FLAG_EN
  assign stage2_out_ovf = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_ovf;
`endif
endmodule
